// File: rtl/sdu_clk_ctrl.sv
// rtl/sdu_clk_ctrl.sv - debug clock controller: single-step, run-to-breakpoint, halt and CPU reset
// Each CPU cycle is a HI/LO pair of clk cycles; all CPU-facing outputs come straight from flops.
module sdu_clk_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_arg,
   input  logic [31:0] pc,
   output logic        cpu_clk,
   output logic        cpu_rstn,
   output logic        done_vld,
   input  logic        done_rdy,
   output logic [1:0]  done_code,
   output logic [31:0] cyc_cnt
);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_STEP_HI, S_STEP_LO, S_RUN_HI, S_RUN_LO, S_RST, S_REPORT
   } state_t;

   localparam logic [1:0] OP_STEP = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_HALT = 2'b10;

   state_t      state_q, state_d;
   logic [2:0]  ph_q, ph_d;
   logic [15:0] step_q, step_d;
   logic [31:0] bp_q, bp_d;
   logic        halt_q, halt_d;
   logic [1:0]  code_q, code_d;
   logic [31:0] cyc_q, cyc_d;
   logic        cpu_clk_q, cpu_clk_d;
   logic        cpu_rstn_q, cpu_rstn_d;
   logic        acc;

   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      step_d     = step_q;
      bp_d       = bp_q;
      halt_d     = halt_q;
      code_d     = code_q;
      cyc_d      = cyc_q;
      cpu_rstn_d = cpu_rstn_q;
      cmd_rdy    = (state_q == S_IDLE) || (state_q == S_RUN_HI) || (state_q == S_RUN_LO);
      acc        = cmd_vld && cmd_rdy;

      case (state_q)
         // ph counts reset slots 1..4; the value after reset (0) is not a slot.
         S_INIT: begin
            ph_d       = ph_q + 3'd1;
            cpu_rstn_d = 1'b0;
            if (ph_q == 3'd4) begin
               state_d    = S_IDLE;
               ph_d       = 3'd0;
               cpu_rstn_d = 1'b1;
            end
         end
         S_IDLE: begin
            if (acc) begin
               case (cmd_op)
                  OP_STEP: begin
                     step_d  = (cmd_arg[15:0] == 16'd0) ? 16'd1 : cmd_arg[15:0];
                     state_d = S_STEP_HI;
                  end
                  OP_RUN: begin
                     bp_d    = cmd_arg;
                     halt_d  = 1'b0;
                     state_d = S_RUN_HI;
                  end
                  OP_HALT: begin
                     code_d  = 2'b10;
                     state_d = S_REPORT;
                  end
                  default: begin
                     ph_d       = 3'd1;
                     cpu_rstn_d = 1'b0;
                     state_d    = S_RST;
                  end
               endcase
            end
         end
         S_STEP_HI: state_d = S_STEP_LO;
         S_STEP_LO: begin
            cyc_d  = cyc_q + 32'd1;
            step_d = step_q - 16'd1;
            if (step_q == 16'd1) begin
               code_d  = 2'b00;
               state_d = S_REPORT;
            end else begin
               state_d = S_STEP_HI;
            end
         end
         S_RUN_HI: begin
            if (acc) halt_d = 1'b1;
            state_d = S_RUN_LO;
         end
         S_RUN_LO: begin
            cyc_d  = cyc_q + 32'd1;
            halt_d = 1'b0;
            if (!bp_q[0] && (pc == bp_q)) begin
               code_d  = 2'b01;
               state_d = S_REPORT;
            end else if (acc || halt_q) begin
               code_d  = 2'b10;
               state_d = S_REPORT;
            end else begin
               state_d = S_RUN_HI;
            end
         end
         S_RST: begin
            ph_d = ph_q + 3'd1;
            if (ph_q == 3'd4) begin
               state_d    = S_REPORT;
               code_d     = 2'b11;
               cyc_d      = 32'd0;
               cpu_rstn_d = 1'b1;
               ph_d       = 3'd0;
            end
         end
         S_REPORT: if (done_rdy) state_d = S_IDLE;
         default:  state_d = S_INIT;
      endcase

      cpu_clk_d = (state_d == S_STEP_HI) || (state_d == S_RUN_HI) ||
                  (((state_d == S_INIT) || (state_d == S_RST)) && ph_d[0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_INIT;
         ph_q       <= 3'd0;
         step_q     <= 16'd0;
         bp_q       <= 32'd0;
         halt_q     <= 1'b0;
         code_q     <= 2'b00;
         cyc_q      <= 32'd0;
         cpu_clk_q  <= 1'b0;
         cpu_rstn_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         step_q     <= step_d;
         bp_q       <= bp_d;
         halt_q     <= halt_d;
         code_q     <= code_d;
         cyc_q      <= cyc_d;
         cpu_clk_q  <= cpu_clk_d;
         cpu_rstn_q <= cpu_rstn_d;
      end
   end

   assign cpu_clk   = cpu_clk_q;
   assign cpu_rstn  = cpu_rstn_q;
   assign done_vld  = (state_q == S_REPORT);
   assign done_code = code_q;
   assign cyc_cnt   = cyc_q;

endmodule

// File: tb/tb_sdu_clk_ctrl.sv
// tb/tb_sdu_clk_ctrl.sv - self-checking bench for sdu_clk_ctrl
// CPU model: pc advances by 4 per cpu_clk rising edge from the start of each command.
module tb_sdu_clk_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_vld = 1'b0;
   logic        cmd_rdy;
   logic [1:0]  cmd_op = 2'b00;
   logic [31:0] cmd_arg = 32'd0;
   logic [31:0] pc;
   logic        cpu_clk, cpu_rstn, done_vld;
   logic        done_rdy = 1'b0;
   logic [1:0]  done_code;
   logic [31:0] cyc_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cpu_edges = 0;
   int unsigned edge_mark = 0;
   logic        pc_fix = 1'b0;
   logic [31:0] pc_val = 32'd0;
   logic [31:0] exp_cyc = 32'd0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] arg;
      logic [1:0]  code;
      int          pulses;
   } vec_t;
   vec_t vt[6];

   sdu_clk_ctrl dut (
      .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
      .cmd_arg(cmd_arg), .pc(pc), .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .done_vld(done_vld), .done_rdy(done_rdy), .done_code(done_code), .cyc_cnt(cyc_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge cpu_clk) cpu_edges++;
   assign pc = pc_fix ? pc_val : 4 * (cpu_edges - edge_mark);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] arg);
      int t = 0;
      while (!cmd_rdy && t < 100) begin
         tick;
         t++;
      end
      if (!cmd_rdy) check("cmd_rdy_timeout", {31'd0, cmd_rdy}, 32'd1);
      edge_mark = cpu_edges;
      cmd_op    = op;
      cmd_arg   = arg;
      cmd_vld   = 1'b1;
      tick;
      cmd_vld   = 1'b0;
   endtask

   task automatic wait_done;
      int t = 0;
      while (!done_vld && t < 300) begin
         tick;
         t++;
      end
      if (!done_vld) check("done_timeout", {31'd0, done_vld}, 32'd1);
   endtask

   task automatic ack;
      done_rdy = 1'b1;
      tick;
      done_rdy = 1'b0;
   endtask

   task automatic halt_now;
      cmd_op  = 2'b10;
      cmd_vld = 1'b1;
      tick;
      cmd_vld = 1'b0;
   endtask

   // Checks a finished report against the model, then consumes it.
   task automatic finish_op(input string name, input logic [1:0] op, input logic [1:0] code, input int pulses);
      wait_done;
      if (op == 2'b11) exp_cyc = 32'd0;
      else exp_cyc = exp_cyc + pulses;
      check({name, "_code"}, {30'd0, done_code}, {30'd0, code});
      check({name, "_pulses"}, cpu_edges - edge_mark, pulses);
      check({name, "_cyc"}, cyc_cnt, exp_cyc);
      check({name, "_clk_lo"}, {31'd0, cpu_clk}, 32'd0);
      ack;
   endtask

   initial begin
      vt[0] = '{op: 2'b00, arg: 32'd3,          code: 2'b00, pulses: 3};
      vt[1] = '{op: 2'b00, arg: 32'd0,          code: 2'b00, pulses: 1};
      vt[2] = '{op: 2'b01, arg: 32'h0000_0010,  code: 2'b01, pulses: 4};
      vt[3] = '{op: 2'b10, arg: 32'd0,          code: 2'b10, pulses: 0};
      vt[4] = '{op: 2'b11, arg: 32'd0,          code: 2'b11, pulses: 2};
      vt[5] = '{op: 2'b00, arg: 32'h0001_0002,  code: 2'b00, pulses: 2};

      // reset and power-up sequence
      tick;
      check("rst_clk", {31'd0, cpu_clk}, 32'd0);
      check("rst_rstn", {31'd0, cpu_rstn}, 32'd0);
      check("rst_done", {31'd0, done_vld}, 32'd0);
      check("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
      check("rst_cyc", cyc_cnt, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("init_clk", {31'd0, cpu_clk}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("init_rstn", {31'd0, cpu_rstn}, 32'd0);
         check("init_rdy", {31'd0, cmd_rdy}, 32'd0);
      end
      tick;
      check("idle_rstn", {31'd0, cpu_rstn}, 32'd1);
      check("idle_rdy", {31'd0, cmd_rdy}, 32'd1);
      check("idle_done", {31'd0, done_vld}, 32'd0);
      check("idle_clk", {31'd0, cpu_clk}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         send(vt[i].op, vt[i].arg);
         finish_op($sformatf("vec%0d", i), vt[i].op, vt[i].code, vt[i].pulses);
      end

      // HALT while in RUN_HI completes the current cycle
      send(2'b01, 32'd1);
      repeat (4) tick;
      check("halt_hi_phase", {31'd0, cpu_clk}, 32'd1);
      halt_now;
      check("halt_hi_lo_clk", {31'd0, cpu_clk}, 32'd0);
      check("halt_hi_lo_done", {31'd0, done_vld}, 32'd0);
      tick;
      check("halt_hi_done", {31'd0, done_vld}, 32'd1);
      finish_op("halt_hi", 2'b10, 2'b10, 3);

      // HALT while in RUN_LO reports immediately
      send(2'b01, 32'd1);
      repeat (3) tick;
      check("halt_lo_phase", {31'd0, cpu_clk}, 32'd0);
      halt_now;
      check("halt_lo_done", {31'd0, done_vld}, 32'd1);
      finish_op("halt_lo", 2'b10, 2'b10, 2);

      // breakpoint and HALT in the same RUN_LO: breakpoint wins
      send(2'b01, 32'd12);
      repeat (5) tick;
      check("bp_halt_phase", {31'd0, cpu_clk}, 32'd0);
      halt_now;
      check("bp_halt_done", {31'd0, done_vld}, 32'd1);
      finish_op("bp_halt", 2'b01, 2'b01, 3);

      // run starting at the breakpoint pc still executes one cycle
      pc_fix = 1'b1;
      pc_val = 32'h0000_0100;
      send(2'b01, 32'h0000_0100);
      finish_op("bp_start", 2'b01, 2'b01, 1);
      pc_fix = 1'b0;

      // report held while done_rdy stays low
      send(2'b00, 32'd2);
      wait_done;
      for (int i = 0; i < 5; i++) begin
         tick;
         check("hold_vld", {31'd0, done_vld}, 32'd1);
         check("hold_code", {30'd0, done_code}, 32'd0);
         check("hold_rdy", {31'd0, cmd_rdy}, 32'd0);
      end
      exp_cyc = exp_cyc + 2;
      check("hold_cyc", cyc_cnt, exp_cyc);
      ack;
      check("hold_idle_rdy", {31'd0, cmd_rdy}, 32'd1);

      // CPU reset after exactly 7 cycles
      send(2'b11, 32'd0);
      finish_op("cr_pre", 2'b11, 2'b11, 2);
      send(2'b00, 32'd7);
      finish_op("step7", 2'b00, 2'b00, 7);
      send(2'b11, 32'd0);
      check("cr_rstn_lo", {31'd0, cpu_rstn}, 32'd0);
      check("cr_clk_hi", {31'd0, cpu_clk}, 32'd1);
      finish_op("cr", 2'b11, 2'b11, 2);
      check("cr_rstn_hi", {31'd0, cpu_rstn}, 32'd1);

      // randomized commands against the reference model
      for (int k = 0; k < 30; k++) begin
         int unsigned r, n;
         r = $urandom_range(0, 8);
         if (r <= 3) begin
            n = $urandom_range(0, 9);
            send(2'b00, n);
            finish_op("rnd_step", 2'b00, 2'b00, (n == 0) ? 1 : n);
         end else if (r <= 6) begin
            n = $urandom_range(1, 6);
            send(2'b01, 4 * n);
            finish_op("rnd_run", 2'b01, 2'b01, n);
         end else if (r == 7) begin
            send(2'b10, $urandom);
            finish_op("rnd_halt", 2'b10, 2'b10, 0);
         end else begin
            send(2'b11, $urandom);
            finish_op("rnd_crst", 2'b11, 2'b11, 2);
         end
      end

      // rst asserted during STEP_HI abandons the step with no report
      begin
         logic seen;
         send(2'b00, 32'd5);
         check("abort_hi", {31'd0, cpu_clk}, 32'd1);
         rst = 1'b1;
         tick;
         rst = 1'b0;
         check("abort_clk", {31'd0, cpu_clk}, 32'd0);
         check("abort_rstn", {31'd0, cpu_rstn}, 32'd0);
         check("abort_cyc", cyc_cnt, 32'd0);
         seen = done_vld;
         for (int i = 0; i < 6; i++) begin
            tick;
            seen = seen | done_vld;
         end
         check("abort_no_report", {31'd0, seen}, 32'd0);
         check("abort_idle_rdy", {31'd0, cmd_rdy}, 32'd1);
         check("abort_idle_rstn", {31'd0, cpu_rstn}, 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sdu_clk_ctrl.md
SDU_CLK_CTRL -- requirements
Module: sdu_clk_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port cmd_vld, input, 1: command valid from debug command processor.
REQ-004 SHALL have port cmd_rdy, output, 1: command accepted when cmd_vld&cmd_rdy at a clk edge.
REQ-005 SHALL have port cmd_op, input, 2: 00 STEP, 01 RUN, 10 HALT, 11 CPU_RESET.
REQ-006 SHALL have port cmd_arg, input, 32: STEP count in [15:0]; RUN breakpoint address, with bit0=1 meaning no breakpoint.
REQ-007 SHALL have port pc, input, 32: current CPU IF-stage PC.
REQ-008 SHALL have port cpu_clk, output, 1: registered CPU clock.
REQ-009 SHALL have port cpu_rstn, output, 1: registered CPU reset, active-low.
REQ-010 SHALL have port done_vld, output, 1: completion report valid.
REQ-011 SHALL have port done_rdy, input, 1: report consumed when done_vld&done_rdy at a clk edge.
REQ-012 SHALL have port done_code, output, 2: 00 steps done, 01 breakpoint hit, 10 halted, 11 reset done.
REQ-013 SHALL have port cyc_cnt, output, 32: CPU cycles issued since last CPU reset.

Function
REQ-014 SHALL implement states INIT, IDLE, STEP_HI, STEP_LO, RUN_HI, RUN_LO, RST, REPORT.
REQ-015 SHALL issue one CPU cycle as two clk cycles: *_HI drives cpu_clk=1, *_LO drives cpu_clk=0; cpu_clk SHALL be 0 in every other state.
REQ-016 SHALL drive cmd_rdy=1 only in IDLE, RUN_HI and RUN_LO.
REQ-017 SHALL, on STEP accepted in IDLE, load step counter with cmd_arg[15:0] (0 treated as 1), then enter STEP_HI.
REQ-018 SHALL, in STEP_LO, decrement the counter; at 1, enter REPORT with code 00; otherwise enter STEP_HI.
REQ-019 SHALL, on RUN accepted in IDLE, latch cmd_arg as breakpoint, then alternate RUN_HI and RUN_LO.
REQ-020 SHALL compare pc to the breakpoint only in RUN_LO, after a completed cycle; a run starting at the breakpoint PC SHALL execute at least one cycle.
REQ-021 SHALL, in RUN_LO on a breakpoint match, enter REPORT with code 01.
REQ-022 SHALL treat any command accepted in RUN_HI or RUN_LO as HALT.
REQ-023 SHALL, on HALT in RUN_HI, finish via RUN_LO, then enter REPORT with code 10.
REQ-024 SHALL, on HALT in RUN_LO, enter REPORT with code 10 directly.
REQ-025 SHALL give breakpoint priority over HALT when both occur in the same RUN_LO: code 01.
REQ-026 SHALL, on HALT accepted in IDLE, enter REPORT with code 10 and issue no CPU cycle.
REQ-027 SHALL, on CPU_RESET accepted in IDLE, enter RST for 4 clk cycles: cpu_rstn=0, cpu_clk pattern 1,0,1,0.
REQ-028 SHALL, after RST, set cpu_rstn=1, clear cyc_cnt, and enter REPORT with code 11.
REQ-029 SHALL hold done_vld=1 and done_code stable in REPORT until done_rdy; then enter IDLE on the next cycle.
REQ-030 SHALL increment cyc_cnt in each STEP_LO/RUN_LO state, wrapping FFFF_FFFF to 0.
REQ-031 SHALL not increment cyc_cnt in RST or INIT.

Reset
REQ-032 SHALL, on rst=1, force: state INIT, cpu_clk=0, cpu_rstn=0, done_vld=0, cmd_rdy=0, cyc_cnt=0, step counter 0, breakpoint 0.
REQ-033 SHALL, on rst asserted mid-operation (any state), abandon the operation with no report, taking effect at the next edge.
REQ-034 SHALL run the same 4-cycle sequence as RST in INIT, then enter IDLE with cpu_rstn=1 and no report.

Verification
REQ-035 SHALL verify: rst 1 cycle, then release -> cpu_clk 1,0,1,0 with cpu_rstn=0; IDLE; cpu_rstn=1; cmd_rdy=1; no done_vld.
REQ-036 SHALL verify: STEP arg=3 -> exactly 3 cpu_clk pulses over 6 clk; done_code=00; cyc_cnt=3; STEP arg=0 -> 1 pulse.
REQ-037 SHALL verify: RUN bp=0x0000_0010 with pc advancing by 4 from 0 -> stop after 4 cycles; code 01; cpu_clk=0.
REQ-038 SHALL verify: RUN arg=1, HALT in RUN_HI -> one more LO; code 10; also check simultaneous bp match and HALT -> code 01.
REQ-039 SHALL verify: done_rdy held 0 for 5 cycles -> done_vld and done_code stable; cmd_rdy=0 throughout.
REQ-040 SHALL verify: CPU_RESET after cyc_cnt=7 -> cyc_cnt=0; code 11; rst during STEP_HI -> cpu_clk=0 next cycle, no report.
